fft_twiddle_seq: RTL and testbench
==================================

Name: fft_twiddle_seq

Overview:
- Frame sequencer for the FFT twiddle-multiply stage.
- On a start handshake it issues one frame of 2^TOTAL_STAGE read addresses to the sample RAM.
- After the RAM latency it presents the aligned enable/address to the twiddle stage's ien/iaddr.
- It counts returning twiddle-stage oen beats and pulses done when the whole frame has come back.

Parameters:
- TOTAL_STAGE, 7: log2 of frame length N; width of all address ports.
- RAM_DLY, 1: sample-RAM read latency in clocks, 1..4; delay from rd_en to ft_en.
- PIPE_DLY, 3: nominal twiddle-stage latency (ien to oen); used only by the optional feature.

Ports:
- iclk, in, 1: single clock, rising edge.
- irst_n, in, 1: reset, asynchronous, active-low.
- istart, in, 1: frame request; held until accepted.
- oready, out, 1: high in IDLE; istart & oready = request accepted.
- ihold, in, 1: stall issuing, e.g. downstream buffer full.
- ord_en, out, 1: sample-RAM read strobe.
- ord_addr, out, TOTAL_STAGE: sample-RAM read address.
- oft_en, out, 1: to twiddle stage ien.
- oft_addr, out, TOTAL_STAGE: to twiddle stage iaddr.
- ift_oen, in, 1: twiddle stage oen, one pulse per completed sample.
- obusy, out, 1: high in ISSUE and DRAIN.
- odone, out, 1: one-cycle frame-complete pulse.
- oerr, out, 1: sticky protocol error; cleared only by reset or the next accepted istart.

Behaviour:
- Reset values: all outputs 0 except oready=1; state IDLE; counters 0.
- Reset is asynchronous at any time, including mid-frame: the frame is abandoned, no odone, delay line flushed.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - oready=1.
  - istart sampled high at cycle T → ISSUE at T+1; oerr cleared at T+1.
  - istart while busy is ignored (oready=0).
- ISSUE:
  - Each cycle with ihold=0: ord_en=1, ord_addr=issue count, count +1.
  - ihold=1: ord_en=0, address held.
  - After the cycle issuing address N-1 → DRAIN.
  - No hold: first ord_en at T+1, last at T+N.
- RAM alignment:
  - oft_en/oft_addr are ord_en/ord_addr passed through a RAM_DLY-stage register line.
  - The line always shifts, independent of ihold and state.
- Return counting:
  - A TOTAL_STAGE+1-bit return counter increments on each ift_oen in ISSUE or DRAIN.
  - DRAIN → DONE in the cycle the counter reaches N; ihold is ignored in DRAIN.
- DONE: odone=1 for exactly one cycle, then IDLE. oready rises the cycle after odone.
- Errors (oerr set):
  - ift_oen received while IDLE or DONE.
  - Return count about to exceed issued count.
  - Out-of-range RAM_DLY (outside 1..4): behaves as 1 and sets oerr out of reset.
- ift_oen in the same cycle as the final issue is counted normally.
- Counters wrap only by design: issue count stops at N, so there is no wrap within a frame.

Optional Feature:
- Macro: FFT_TWIDDLE_SEQ_BITREV_EN.
  - Defined: ord_addr is the bit-reversed issue count, so a natural-order RAM is read in bit-reversed order. oft_addr is still the natural-order count, delayed by RAM_DLY, so twiddle indexing is unchanged.
  - Undefined: ord_addr is the natural issue count, identical to undelayed oft_addr.
- Independently of the macro, PIPE_DLY sets a drain watchdog: in DRAIN, if more than 4*PIPE_DLY+N cycles pass without completion → oerr=1 and force DONE, with odone still pulsed.

Decomposition:
- Shared FFT package/include holds:
  - state encoding constants;
  - TOTAL_STAGE default;
  - SIM_DLY;
  - a bit-reverse function, reused by the bit-reverse feature and by other FFT stages.
- One natural sub-module: fft_dly_line (width, depth), the RAM_DLY alignment register chain with async active-low reset.

Test Plan:
Bench model: ift_oen = oft_en delayed 3 cycles. Defaults TOTAL_STAGE=7, RAM_DLY=1. istart accepted at cycle 0.
1. No hold:
   - ord_en high cycles 1..128, ord_addr 0..127.
   - oft_en cycles 2..129, oft_addr 0..127.
   - odone at cycle 133; oready=1 at 134; oerr=0.
2. ihold=1 for cycles 10..14:
   - ord_addr holds 9, ord_en=0 those cycles; resumes at 10.
   - odone shifts 5 cycles to 138.
3. irst_n low at cycle 60, high at 62:
   - All outputs at reset values from cycle 60.
   - No odone; new istart at 70 runs a full clean frame.
4. Extra ift_oen pulse while IDLE: oerr=1 and stays 1; cleared the cycle after the next accepted istart.
5. FFT_TWIDDLE_SEQ_BITREV_EN defined, TOTAL_STAGE=3:
   - ord_addr sequence 0,4,2,6,1,5,3,7.
   - oft_addr 0..7 one cycle later.
6. Bench drops the last ift_oen: watchdog fires after 4*3+8 cycles in DRAIN with TOTAL_STAGE=3 → oerr=1, odone pulses, back to IDLE.

Source files
------------

// File: rtl/fft_twiddle_seq_pkg.sv
// Shared FFT definitions: sequencer state encoding, default frame size and bit-reversal.
// Also used by the other FFT stages and their benches.
package fft_twiddle_seq_pkg;

   localparam int TOTAL_STAGE_DEF = 7;
   localparam int SIM_DLY         = 1;
   localparam int BITREV_MAX_W    = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } seq_state_e;

   // Reverses the low w bits of v; bits at and above w come back zero.
   function automatic logic [BITREV_MAX_W-1:0] bit_rev(input logic [BITREV_MAX_W-1:0] v,
                                                       input int w);
      logic [BITREV_MAX_W-1:0] r;
      r = {<<{v}};
      return r >> (BITREV_MAX_W - w);
   endfunction

endpackage

// File: rtl/fft_twiddle_seq_if.sv
// Control, sample-RAM read and twiddle-stage link of the twiddle sequencer.
interface fft_twiddle_seq_if
   import fft_twiddle_seq_pkg::*;
#(
   parameter int TOTAL_STAGE = TOTAL_STAGE_DEF
) ();
   logic                   istart;
   logic                   oready;
   logic                   ihold;
   logic                   ord_en;
   logic [TOTAL_STAGE-1:0] ord_addr;
   logic                   oft_en;
   logic [TOTAL_STAGE-1:0] oft_addr;
   logic                   ift_oen;
   logic                   obusy;
   logic                   odone;
   logic                   oerr;

   modport master (
      input  istart, ihold, ift_oen,
      output oready, ord_en, ord_addr, oft_en, oft_addr, obusy, odone, oerr
   );

   modport slave (
      output istart, ihold, ift_oen,
      input  oready, ord_en, ord_addr, oft_en, oft_addr, obusy, odone, oerr
   );
endinterface

// File: rtl/fft_dly_line.sv
// Register chain that lines read strobes/addresses up with the sample RAM's read latency.
module fft_dly_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             iclk,
   input  logic             irst_n,
   input  logic [WIDTH-1:0] id,
   output logic [WIDTH-1:0] od
);
   logic [WIDTH-1:0] stage_q [DEPTH];

   // NOTE: every stage is reset, not just the strobe bit, so a mid-frame reset cannot replay stale addresses.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= id;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign od = stage_q[DEPTH-1];
endmodule

// File: rtl/fft_twiddle_seq.sv
// Twiddle-stage frame sequencer: issues 2^TOTAL_STAGE RAM reads, aligns them to the twiddle
// stage and counts returns. Macro FFT_TWIDDLE_SEQ_BITREV_EN reads the RAM in bit-reversed order.
module fft_twiddle_seq
   import fft_twiddle_seq_pkg::*;
#(
   parameter int TOTAL_STAGE = TOTAL_STAGE_DEF,
   parameter int RAM_DLY     = 1,
   parameter int PIPE_DLY    = 3
) (
   input logic               iclk,
   input logic               irst_n,
   fft_twiddle_seq_if.master bus
);
   localparam int N        = 1 << TOTAL_STAGE;
   localparam bit DLY_OK   = (RAM_DLY >= 1) && (RAM_DLY <= 4);
   localparam int EFF_DLY  = DLY_OK ? RAM_DLY : 1;
   localparam int WD_LIMIT = 4 * PIPE_DLY + N;
   localparam int WD_W     = $clog2(WD_LIMIT + 1);
   localparam logic [TOTAL_STAGE:0] LAST_CNT = (TOTAL_STAGE + 1)'(N - 1);
   localparam logic [WD_W-1:0]      WD_FIRE  = WD_W'(WD_LIMIT);

   seq_state_e           state_q, state_d;
   logic [TOTAL_STAGE:0] iss_q, iss_d;
   logic [TOTAL_STAGE:0] ret_q, ret_d;
   logic [WD_W-1:0]      wd_q, wd_d;
   logic                 err_q, err_d;
   logic                 rd_en;
   logic                 complete;
   logic [TOTAL_STAGE:0] ft_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= S_IDLE;
         iss_q   <= '0;
         ret_q   <= '0;
         wd_q    <= '0;
         err_q   <= !DLY_OK;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         ret_q   <= ret_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      iss_d    = iss_q;
      ret_d    = ret_q;
      wd_d     = '0;
      err_d    = err_q;
      rd_en    = 1'b0;
      complete = 1'b0;

      if (bus.ift_oen) begin
         if (state_q == S_IDLE || state_q == S_DONE || ret_q >= iss_q) begin
            err_d = 1'b1;
         end else begin
            ret_d    = ret_q + 1'b1;
            complete = (ret_q == LAST_CNT);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.istart) begin
               state_d = S_ISSUE;
               iss_d   = '0;
               ret_d   = '0;
               err_d   = bus.ift_oen;
            end
         end
         S_ISSUE: begin
            if (!bus.ihold) begin
               rd_en = 1'b1;
               iss_d = iss_q + 1'b1;
               if (iss_q == LAST_CNT) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Watchdog fires once more than WD_LIMIT drain cycles have gone by without completion.
            wd_d = wd_q + 1'b1;
            if (complete) begin
               state_d = S_DONE;
            end else if (wd_q == WD_FIRE) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   fft_dly_line #(
      .WIDTH (TOTAL_STAGE + 1),
      .DEPTH (EFF_DLY)
   ) u_dly (
      .iclk   (iclk),
      .irst_n (irst_n),
      .id     ({rd_en, iss_q[TOTAL_STAGE-1:0]}),
      .od     (ft_q)
   );

   assign {bus.oft_en, bus.oft_addr} = ft_q;

`ifdef FFT_TWIDDLE_SEQ_BITREV_EN
   assign bus.ord_addr = TOTAL_STAGE'(bit_rev(BITREV_MAX_W'(iss_q[TOTAL_STAGE-1:0]), TOTAL_STAGE));
`else
   assign bus.ord_addr = iss_q[TOTAL_STAGE-1:0];
`endif

   assign bus.ord_en = rd_en;
   assign bus.oready = (state_q == S_IDLE);
   assign bus.obusy  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign bus.odone  = (state_q == S_DONE);
   assign bus.oerr   = err_q;
endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Bench for fft_twiddle_seq: twiddle stage modelled as oen = oft_en delayed 3 cycles,
// beats checked against a queue of expected (cycle, address) entries.
module tb_fft_twiddle_seq;
   import fft_twiddle_seq_pkg::*;

   typedef struct {
      int         due;
      logic [6:0] addr;
   } beat_t;

   localparam logic [19:0] RST7 = 20'h80000;
   localparam logic [2:0]  BR3 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

   logic iclk = 1'b0;
   logic irst_n;
   int   checks = 0;
   int   errors = 0;

   logic [2:0] pipe7 = '0;
   logic [2:0] pipe3 = '0;
   int         beats3 = 0;
   bit         drop_last3 = 1'b0;

   fft_twiddle_seq_if #(.TOTAL_STAGE(7)) b7 ();
   fft_twiddle_seq_if #(.TOTAL_STAGE(3)) b3 ();
   fft_twiddle_seq_if #(.TOTAL_STAGE(3)) bx ();

   fft_twiddle_seq #(.TOTAL_STAGE(7), .RAM_DLY(1), .PIPE_DLY(3)) dut7 (
      .iclk(iclk), .irst_n(irst_n), .bus(b7));
   fft_twiddle_seq #(.TOTAL_STAGE(3), .RAM_DLY(1), .PIPE_DLY(3)) dut3 (
      .iclk(iclk), .irst_n(irst_n), .bus(b3));
   fft_twiddle_seq #(.TOTAL_STAGE(3), .RAM_DLY(5), .PIPE_DLY(3)) dutx (
      .iclk(iclk), .irst_n(irst_n), .bus(bx));

   always #5 iclk = ~iclk;

   function automatic logic [6:0] rd7(input logic [6:0] v);
`ifdef FFT_TWIDDLE_SEQ_BITREV_EN
      logic [6:0] r;
      r = {<<{v}};
      return r;
`else
      return v;
`endif
   endfunction

   function automatic logic [2:0] rd3(input logic [2:0] v);
`ifdef FFT_TWIDDLE_SEQ_BITREV_EN
      return BR3[v];
`else
      return v;
`endif
   endfunction

   function automatic logic [19:0] out7();
      return {b7.oready, b7.ord_en, b7.ord_addr, b7.oft_en, b7.oft_addr,
              b7.obusy, b7.odone, b7.oerr};
   endfunction

   // Advance to the next falling edge and update the twiddle-stage return models.
   task automatic tick();
      @(negedge iclk);
      b7.ift_oen = pipe7[2];
      pipe7      = {pipe7[1:0], b7.oft_en};
      b3.ift_oen = pipe3[2];
      pipe3      = {pipe3[1:0], b3.oft_en && !(drop_last3 && beats3 == 7)};
      if (b3.oft_en) beats3++;
   endtask

   task automatic frame7(input int hold_from, input int hold_len, input logic err0,
                         output int done_obs);
      beat_t q[$];
      int    exp_cnt, done_at;
      bit    seen;
      exp_cnt = 0; done_at = 1 << 30; seen = 1'b0; done_obs = -1;
      tick();
      b7.istart = 1'b1;
      #SIM_DLY;
      checks++;
      if (b7.oready !== 1'b1 || b7.oerr !== err0) begin
         errors++;
         $display("FAIL accept7: oready=%b oerr=%b, required 1 %b", b7.oready, b7.oerr, err0);
      end
      for (int r = 1; r < 400 && !seen; r++) begin
         tick();
         b7.istart = 1'b0;
         b7.ihold  = (r >= hold_from) && (r < hold_from + hold_len);
         #SIM_DLY;
         checks++;
         if (exp_cnt < 128) begin
            if (b7.ord_en !== !b7.ihold || b7.ord_addr !== rd7(exp_cnt[6:0])) begin
               errors++;
               $display("FAIL rd7 r=%0d: ord_en=%b ord_addr=%0d, required %b %0d",
                        r, b7.ord_en, b7.ord_addr, !b7.ihold, rd7(exp_cnt[6:0]));
            end
            if (!b7.ihold) begin
               q.push_back('{r + 1, exp_cnt[6:0]});
               exp_cnt++;
               if (exp_cnt == 128) done_at = r + 5;
            end
         end else if (b7.ord_en !== 1'b0) begin
            errors++;
            $display("FAIL rd7_idle r=%0d: ord_en=%b, required 0", r, b7.ord_en);
         end
         checks++;
         if (q.size() > 0 && q[0].due == r) begin
            if (b7.oft_en !== 1'b1 || b7.oft_addr !== q[0].addr) begin
               errors++;
               $display("FAIL ft7 r=%0d: oft_en=%b oft_addr=%0d, required 1 %0d",
                        r, b7.oft_en, b7.oft_addr, q[0].addr);
            end
            void'(q.pop_front());
         end else if (b7.oft_en !== 1'b0) begin
            errors++;
            $display("FAIL ft7_idle r=%0d: oft_en=%b, required 0", r, b7.oft_en);
         end
         checks++;
         if ({b7.odone, b7.obusy, b7.oerr} !== {r == done_at, r < done_at, 1'b0}) begin
            errors++;
            $display("FAIL status7 r=%0d: done/busy/err=%b%b%b, required %b%b0",
                     r, b7.odone, b7.obusy, b7.oerr, r == done_at, r < done_at);
         end
         if (b7.odone === 1'b1 && done_obs < 0) done_obs = r;
         if (r == done_at + 1) begin
            seen = 1'b1;
            checks++;
            if (b7.oready !== 1'b1 || q.size() != 0) begin
               errors++;
               $display("FAIL ready7 r=%0d: oready=%b pending=%0d, required 1 0",
                        r, b7.oready, q.size());
            end
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout7: frame did not finish, required odone then oready");
      end
   endtask

   task automatic frame3(input bit drop, output int done_obs);
      beat_t q[$];
      int    exp_cnt, done_at;
      bit    seen;
      exp_cnt = 0; done_at = 1 << 30; seen = 1'b0; done_obs = -1;
      beats3 = 0; drop_last3 = drop;
      tick();
      b3.istart = 1'b1;
      #SIM_DLY;
      checks++;
      if (b3.oready !== 1'b1) begin
         errors++;
         $display("FAIL accept3: oready=%b, required 1", b3.oready);
      end
      for (int r = 1; r < 100 && !seen; r++) begin
         tick();
         b3.istart = 1'b0;
         #SIM_DLY;
         checks++;
         if (exp_cnt < 8) begin
            if (b3.ord_en !== 1'b1 || b3.ord_addr !== rd3(exp_cnt[2:0])) begin
               errors++;
               $display("FAIL rd3 r=%0d: ord_en=%b ord_addr=%0d, required 1 %0d",
                        r, b3.ord_en, b3.ord_addr, rd3(exp_cnt[2:0]));
            end
            q.push_back('{r + 1, exp_cnt[6:0]});
            exp_cnt++;
            // Dropped return: drain starts next cycle, watchdog needs 4*3+8 full cycles then one more.
            if (exp_cnt == 8) done_at = drop ? r + 22 : r + 5;
         end else if (b3.ord_en !== 1'b0) begin
            errors++;
            $display("FAIL rd3_idle r=%0d: ord_en=%b, required 0", r, b3.ord_en);
         end
         checks++;
         if (q.size() > 0 && q[0].due == r) begin
            if (b3.oft_en !== 1'b1 || {4'b0, b3.oft_addr} !== q[0].addr) begin
               errors++;
               $display("FAIL ft3 r=%0d: oft_en=%b oft_addr=%0d, required 1 %0d",
                        r, b3.oft_en, b3.oft_addr, q[0].addr);
            end
            void'(q.pop_front());
         end else if (b3.oft_en !== 1'b0) begin
            errors++;
            $display("FAIL ft3_idle r=%0d: oft_en=%b, required 0", r, b3.oft_en);
         end
         checks++;
         if ({b3.odone, b3.obusy, b3.oerr} !== {r == done_at, r < done_at, drop && r >= done_at}) begin
            errors++;
            $display("FAIL status3 r=%0d: done/busy/err=%b%b%b, required %b%b%b", r,
                     b3.odone, b3.obusy, b3.oerr, r == done_at, r < done_at, drop && r >= done_at);
         end
         if (b3.odone === 1'b1 && done_obs < 0) done_obs = r;
         if (r == done_at + 1) begin
            seen = 1'b1;
            checks++;
            if (b3.oready !== 1'b1) begin
               errors++;
               $display("FAIL ready3 r=%0d: oready=%b, required 1", r, b3.oready);
            end
         end
      end
      drop_last3 = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout3: frame did not finish, required odone then oready");
      end
   endtask

   task automatic test_reset();
      #SIM_DLY;
      checks++;
      if (out7() !== RST7 || b3.oready !== 1'b1 || b3.oerr !== 1'b0) begin
         errors++;
         $display("FAIL reset: outputs=%h ready3=%b err3=%b, required %h 1 0",
                  out7(), b3.oready, b3.oerr, RST7);
      end
   endtask

   task automatic test_bad_dly();
      checks++;
      if (bx.oerr !== 1'b1 || bx.oready !== 1'b1) begin
         errors++;
         $display("FAIL bad_dly: oerr=%b oready=%b, required 1 1", bx.oerr, bx.oready);
      end
   endtask

   task automatic test_no_hold();
      int d;
      frame7(1000, 0, 1'b0, d);
      checks++;
      if (d != 133) begin
         errors++;
         $display("FAIL no_hold_done: odone at %0d, required 133", d);
      end
   endtask

   task automatic test_hold();
      int d;
      frame7(10, 5, 1'b0, d);
      checks++;
      if (d != 138) begin
         errors++;
         $display("FAIL hold_done: odone at %0d, required 138", d);
      end
   endtask

   task automatic test_reset_mid();
      int d;
      tick();
      b7.istart = 1'b1;
      for (int r = 1; r < 60; r++) begin
         tick();
         b7.istart = 1'b0;
      end
      #SIM_DLY;
      checks++;
      if (b7.obusy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: obusy=%b, required 1", b7.obusy);
      end
      for (int r = 60; r < 70; r++) begin
         tick();
         if (r == 60) begin
            irst_n = 1'b0;
            pipe7 = '0;
            b7.ift_oen = 1'b0;
         end
         if (r == 62) irst_n = 1'b1;
         #SIM_DLY;
         checks++;
         if (out7() !== RST7) begin
            errors++;
            $display("FAIL mid_reset r=%0d: outputs=%h, required %h", r, out7(), RST7);
         end
      end
      frame7(1000, 0, 1'b0, d);
      checks++;
      if (d != 133) begin
         errors++;
         $display("FAIL post_reset_done: odone at %0d, required 133", d);
      end
   endtask

   task automatic test_err_idle();
      int d;
      tick();
      b7.ift_oen = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         #SIM_DLY;
         checks++;
         if (b7.oerr !== 1'b1) begin
            errors++;
            $display("FAIL err_idle k=%0d: oerr=%b, required 1", k, b7.oerr);
         end
      end
      frame7(1000, 0, 1'b1, d);
   endtask

   task automatic test_bitrev();
      int d;
      frame3(1'b0, d);
      checks++;
      if (d != 13) begin
         errors++;
         $display("FAIL small_done: odone at %0d, required 13", d);
      end
   endtask

   task automatic test_watchdog();
      int d;
      frame3(1'b1, d);
      checks++;
      if (d != 30) begin
         errors++;
         $display("FAIL watchdog_done: odone at %0d, required 30", d);
      end
      tick();
      #SIM_DLY;
      checks++;
      if (b3.oerr !== 1'b1 || b3.oready !== 1'b1) begin
         errors++;
         $display("FAIL watchdog_idle: oerr=%b oready=%b, required 1 1", b3.oerr, b3.oready);
      end
   endtask

   initial begin
      irst_n = 1'b0;
      b7.istart = 1'b0; b7.ihold = 1'b0; b7.ift_oen = 1'b0;
      b3.istart = 1'b0; b3.ihold = 1'b0; b3.ift_oen = 1'b0;
      bx.istart = 1'b0; bx.ihold = 1'b0; bx.ift_oen = 1'b0;
      test_reset();
      repeat (2) @(negedge iclk);
      irst_n = 1'b1;
      test_reset();
      test_bad_dly();
      test_no_hold();
      test_hold();
      test_reset_mid();
      test_err_idle();
      test_bitrev();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
